aes_round_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_round_stage.sv | 64 ++++++
 rtl/aes_round_iter.sv | 122 ++++++++++++
 tb/tb_aes_round_iter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block/key-schedule widths, engine FSM states
// and the round-key selector used by the iterative core.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;
    localparam int AES_RK_W  = 1408;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Round key idx lives in rk[128*idx +: 128]; indices above AES_NR give zero.
    function automatic logic [AES_BLK_W-1:0] rk_slice(input logic [AES_RK_W-1:0] rk,
                                                      input logic [3:0]          idx);
        logic [AES_BLK_W-1:0] k;
        k = '0;
        for (int i = 0; i <= AES_NR; i++) begin
            if (idx == 4'(i)) begin
                k = rk[i*AES_BLK_W +: AES_BLK_W];
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/aes_round_stage.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns, AddRoundKey. Byte 0 of the block sits in [127:120] and the
// state is column-major (byte index = row + 4*column).
module aes_round_stage
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_in,
    input  logic [AES_BLK_W-1:0] round_key,
    input  logic                 disable_mix,
    output logic [AES_BLK_W-1:0] state_out
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, which also maps 0 to 0) plus the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int k = 7; k >= 0; k--) begin
            inv = gf_mul(inv, inv);
            if (k != 0) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = sbox(state_in[AES_BLK_W-1-8*i -: 8]);
    end

    // ShiftRows rotates row r left by r columns; MixColumns mixes each column.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[r+4*c] = sb[r+4*((c+r)%4)];
            assign mc[r+4*c] = xtime(sr[r+4*c])
                             ^ xtime(sr[((r+1)%4)+4*c]) ^ sr[((r+1)%4)+4*c]
                             ^ sr[((r+2)%4)+4*c] ^ sr[((r+3)%4)+4*c];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign state_out[AES_BLK_W-1-8*i -: 8] =
            (disable_mix ? sr[i] : mc[i]) ^ round_key[AES_BLK_W-1-8*i -: 8];
    end

endmodule

// File: rtl/aes_round_iter.sv
// Iterative AES-128 encryption core. ROUNDS_PER_CYCLE round stages are
// chained per clock; a block is accepted in IDLE (or in DONE alongside the
// output handshake), iterated in RUN and held in DONE until taken.
module aes_round_iter
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int TAG_W            = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [AES_RK_W-1:0]  round_keys,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
        $error("aes_round_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    localparam logic [3:0] RPC4     = 4'(ROUNDS_PER_CYCLE);
    localparam logic [3:0] LAST_RND = 4'(AES_NR);

    aes_state_e           state_q, state_d;
    logic [3:0]           rnd_q, rnd_d;
    logic [AES_BLK_W-1:0] blk_q, blk_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 accept;

    // Round chain: stage g applies round rnd_q+g; only round 10 skips MixColumns.
    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_stage
        logic [3:0]           idx;
        logic [AES_BLK_W-1:0] s_in;
        logic [AES_BLK_W-1:0] s_out;
        assign idx = rnd_q + 4'(g);
        if (g == 0) begin : g_first
            assign s_in = blk_q;
        end else begin : g_next
            assign s_in = g_stage[g-1].s_out;
        end
        aes_round_stage u_stage (
            .state_in   (s_in),
            .round_key  (rk_slice(round_keys, idx)),
            .disable_mix(idx == LAST_RND),
            .state_out  (s_out)
        );
    end

    // In DONE a new block may enter only on the same edge the result leaves.
    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = blk_q;
    assign out_tag   = tag_q;

    // Next-state, counter and datapath-register update selection.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    rnd_d   = 4'd1;
                    blk_d   = in_data ^ rk_slice(round_keys, 4'd0);
                    tag_d   = in_tag;
                end
            end
            RUN: begin
                blk_d = g_stage[ROUNDS_PER_CYCLE-1].s_out;
                rnd_d = rnd_q + RPC4;
                if (rnd_q + RPC4 - 4'd1 == LAST_RND) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = RUN;
                        rnd_d   = 4'd1;
                        blk_d   = in_data ^ rk_slice(round_keys, 4'd0);
                        tag_d   = in_tag;
                    end else begin
                        state_d = IDLE;
                        rnd_d   = 4'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                rnd_d   = 4'd0;
            end
        endcase
    end

    // State, round counter, block and tag registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            blk_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_aes_round_iter.sv
// Bench for aes_round_iter: a reference AES-128 model (table S-box built by
// inverse search, textbook key expansion) feeds a scoreboard that checks the
// main core every cycle; extra cores cover the other round-unroll factors.
module tb_aes_round_iter;

    localparam int TAG_W  = 4;
    localparam int N_MAIN = 10;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0]       in_data, out_data;
    logic [TAG_W-1:0]   in_tag, out_tag;
    logic [1407:0]      round_keys;

    logic               x_in_valid;
    logic [127:0]       x_in_data;
    logic [TAG_W-1:0]   x_in_tag;
    logic [1407:0]      x_rk;
    logic [2:0]         x_in_ready, x_out_valid, x_busy;
    logic [127:0]       x_out_data [3];
    logic [TAG_W-1:0]   x_out_tag [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] sbox_t [256];

    typedef struct {
        logic [127:0]     ct;
        logic [TAG_W-1:0] tag;
        int               acc;
    } item_t;
    item_t q[$];
    int    out_cycles[$];
    int    out_tags[$];

    always #5 clk = ~clk;

    aes_round_iter #(.ROUNDS_PER_CYCLE(1), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .round_keys(round_keys),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_x
        aes_round_iter #(.ROUNDS_PER_CYCLE(g == 0 ? 2 : (g == 1 ? 5 : 10)), .TAG_W(TAG_W)) u_x (
            .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready[g]),
            .in_data(x_in_data), .in_tag(x_in_tag), .round_keys(x_rk),
            .out_valid(x_out_valid[g]), .out_ready(1'b1), .out_data(x_out_data[g]),
            .out_tag(x_out_tag[g]), .busy(x_busy[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        int x, y, p;
        x = int'(a); y = int'(b); p = 0;
        while (y != 0) begin
            if (y % 2 == 1) p = p ^ x;
            x = x * 2;
            if (x >= 256) x = x ^ 'h11B;
            y = y / 2;
        end
        return p[7:0];
    endfunction

    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            int inv;
            logic [7:0] iv, s;
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = y;
            iv = 8'(inv);
            for (int i = 0; i < 8; i++)
                s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 8'h00;
            sbox_t[x] = s;
        end
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] rk;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] model_enc(input logic [1407:0] rk, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k, o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            k = rk[128*r +: 128];
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w+4*c] = s[w + 4*((c+w)%4)];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    if (r < 10)
                        s[w+4*c] = m_mul(8'h02, t[w+4*c]) ^ m_mul(8'h03, t[(w+1)%4+4*c])
                                 ^ t[(w+2)%4+4*c] ^ t[(w+3)%4+4*c];
                    else
                        s[w+4*c] = t[w+4*c];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (busy=%0d out_valid=%0d)", name, busy, out_valid);
    endtask

    // Scoreboard: one in-flight item; result due N+1 negedges after the accept sample.
    always @(negedge clk) begin : mon
        bit ev;
        cyc++;
        if (!rst_n) begin
            q.delete();
            chk_i("rst_out_valid", int'(out_valid), 0);
            chk_i("rst_busy", int'(busy), 0);
            chk_i("rst_in_ready", int'(in_ready), 0);
            chk_i("rst_out_tag", int'(out_tag), 0);
        end else begin
            ev = (q.size() > 0) && (cyc - q[0].acc > N_MAIN);
            chk_i("out_valid", int'(out_valid), int'(ev));
            chk_i("busy", int'(busy), int'(q.size() > 0));
            chk_i("in_ready", int'(in_ready), int'((q.size() == 0) || (ev && out_ready)));
            if (out_valid && q.size() > 0) begin
                chk("out_data", out_data, q[0].ct);
                chk_i("out_tag", int'(out_tag), int'(q[0].tag));
            end
            if (out_valid && out_ready && q.size() > 0) begin
                out_cycles.push_back(cyc);
                out_tags.push_back(int'(out_tag));
                void'(q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back('{ct: model_enc(round_keys, in_data), tag: in_tag, acc: cyc});
        end
    end

    // Present a block and hold it until accepted; returns 1 ns after the accept edge.
    task automatic send_block(input logic [127:0] d, input logic [TAG_W-1:0] t);
        in_data = d; in_tag = t; in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                return;
            end
        end
        timeout("send_block");
    endtask

    // Called 1 ns after an accept edge; lat = clocks from that edge to out_valid.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k - 1;
                return;
            end
        end
        timeout("wait_out");
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        timeout("drain");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int xlat [3];
        logic [127:0] blk_a, blk_b, exp_a, exp_b;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_tag = '0;
        x_in_valid = 1'b0; x_in_data = '0; x_in_tag = '0;
        build_sbox();
        round_keys = expand(KEY1);
        x_rk = round_keys;

        // Pin the model against published vectors.
        chk("model_c1", model_enc(expand(KEY1), PT1), CT1);
        chk("model_zero", model_enc(expand(128'h0), 128'h0), CT0);
        chk("model_rk10", expand(128'h2b7e151628aed2a6abf7158809cf4f3c) >> 1280,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: FIPS-197 C.1 on the one-round-per-clock core.
        @(posedge clk); #1;
        send_block(PT1, 4'h5);
        in_valid = 1'b0;
        wait_out(lat);
        chk_i("t1_latency", lat, 10);
        chk("t1_data", out_data, CT1);
        chk_i("t1_tag", int'(out_tag), 5);

        // 2: unrolled cores, C.1 vector and all-zero vector.
        for (int v = 0; v < 2; v++) begin
            x_rk      = expand(v == 0 ? KEY1 : 128'h0);
            x_in_data = (v == 0) ? PT1 : 128'h0;
            x_in_tag  = 4'(v + 3);
            for (int g = 0; g < 3; g++) begin
                chk_i("t2_idle_ready", int'(x_in_ready[g]), 1);
                chk_i("t2_idle_busy", int'(x_busy[g]), 0);
                xlat[g] = -1;
            end
            @(posedge clk); #1 x_in_valid = 1'b1;
            @(posedge clk); #1 x_in_valid = 1'b0;
            for (int k = 1; k <= 15; k++) begin
                @(negedge clk);
                for (int g = 0; g < 3; g++) begin
                    if (x_out_valid[g] && xlat[g] < 0) begin
                        xlat[g] = k - 1;
                        chk("t2_data", x_out_data[g], (v == 0) ? CT1 : CT0);
                        chk_i("t2_tag", int'(x_out_tag[g]), v + 3);
                    end
                end
            end
            chk_i("t2_lat_rpc2", xlat[0], 5);
            chk_i("t2_lat_rpc5", xlat[1], 2);
            chk_i("t2_lat_rpc10", xlat[2], 1);
        end

        // 3 + 6: backpressure, then handshake and new accept on the same edge.
        blk_a = {$urandom, $urandom, $urandom, $urandom};
        blk_b = ~blk_a ^ PT1;
        exp_a = model_enc(round_keys, blk_a);
        exp_b = model_enc(round_keys, blk_b);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_block(blk_a, 4'h7);
        in_valid = 1'b0;
        wait_out(lat);
        chk_i("t3_latency", lat, 10);
        @(posedge clk); #1;
        in_data = blk_b; in_tag = 4'h8; in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("t3_hold_data", out_data, exp_a);
            chk_i("t3_hold_tag", int'(out_tag), 7);
            chk_i("t3_hold_valid", int'(out_valid), 1);
            chk_i("t3_in_ready", int'(in_ready), 0);
            chk_i("t3_busy", int'(busy), 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        wait_out(lat);
        chk_i("t6_latency", lat, 10);
        chk("t6_data", out_data, exp_b);
        chk_i("t6_tag", int'(out_tag), 8);

        // 4: three blocks back to back.
        @(posedge clk); #1;
        out_cycles.delete();
        out_tags.delete();
        send_block({$urandom, $urandom, $urandom, $urandom}, 4'h1);
        send_block({$urandom, $urandom, $urandom, $urandom}, 4'h2);
        send_block({$urandom, $urandom, $urandom, $urandom}, 4'h3);
        in_valid = 1'b0;
        for (int k = 0; k < 60 && out_cycles.size() < 3; k++) @(negedge clk);
        chk_i("t4_count", out_cycles.size(), 3);
        if (out_cycles.size() >= 3) begin
            chk_i("t4_gap1", out_cycles[1] - out_cycles[0], 11);
            chk_i("t4_gap2", out_cycles[2] - out_cycles[1], 11);
            chk_i("t4_tag0", out_tags[0], 1);
            chk_i("t4_tag1", out_tags[1], 2);
            chk_i("t4_tag2", out_tags[2], 3);
        end
        drain();

        // 5: asynchronous reset during RUN, then a clean block.
        @(posedge clk); #1;
        send_block(PT1, 4'h9);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_i("t5_async_valid", int'(out_valid), 0);
        chk_i("t5_async_busy", int'(busy), 0);
        chk_i("t5_async_ready", int'(in_ready), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send_block(PT1, 4'h4);
        in_valid = 1'b0;
        wait_out(lat);
        chk_i("t5_latency", lat, 10);
        chk("t5_data", out_data, CT1);
        chk_i("t5_tag", int'(out_tag), 4);
        drain();

        // Random traffic under a random key.
        round_keys = expand({$urandom, $urandom, $urandom, $urandom});
        for (int k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 2) == 1;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom % 4) != 0;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
